// File: rtl/rv_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_trace_pkg
// Description : Shared types for the FlexRV32 retirement trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_trace_pkg;

  localparam int c_trace_pc_bits = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    MODE_WRAP      = 2'd0,
    MODE_STOP_FULL = 2'd1,
    MODE_TRIGGER   = 2'd2
  } trace_mode_t;

  typedef struct packed {
    logic [c_trace_pc_bits-1:0] pc;
    logic [31:0]                instr;
    logic [31:0]                data;
    logic [31:0]                addr;
    logic [2:0]                 flags;
  } trace_entry_t;

  typedef struct packed {
    logic [c_trace_pc_bits-1:0] pc;
    logic [31:0]                instr;
    logic [2:0]                 flags;
  } trace_stage_t;

  // Reserved encoding 3 falls back to free-running capture.
  function automatic trace_mode_t decode_mode(input logic [1:0] mode);
    case (mode)
      2'd1:    return MODE_STOP_FULL;
      2'd2:    return MODE_TRIGGER;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_trace_buffer_if
// Description : Debug-host read port of the trace buffer (request/valid pop).
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_trace_buffer_if #(
  parameter int IADDR_SPACE_BITS = 32
);
  logic                        i_rd_req;
  logic                        o_rd_valid;
  logic [IADDR_SPACE_BITS-1:0] o_rd_pc;
  logic [31:0]                 o_rd_instr;
  logic [31:0]                 o_rd_data;
  logic [31:0]                 o_rd_addr;
  logic [2:0]                  o_rd_flags;

  modport master (
    output i_rd_req,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_data, o_rd_addr, o_rd_flags
  );

  modport slave (
    input  i_rd_req,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_data, o_rd_addr, o_rd_flags
  );
endinterface
`default_nettype wire

// File: rtl/rv_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : rv_trace_ram
// Description : DEPTH x trace_entry_t storage, one write port, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_trace_ram
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic                     i_clk,
  input  wire logic                     i_reset,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
  input  wire trace_entry_t             i_wdata,
  input  wire logic                     i_re,
  input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
  output trace_entry_t                  o_rdata
);

  trace_entry_t mem_q [DEPTH];
  trace_entry_t rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value between pops so the host sees stable data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/rv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rv_trace_buffer
// Description : Retirement trace buffer: shadow pipeline, circular capture
//               with wrap / stop-on-full / PC-trigger modes, oldest-first drain.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int DEPTH            = 16,
  parameter int PIPE_STAGES      = 3
) (
  input  wire logic                          i_clk,
  input  wire logic                          i_reset,
  input  wire logic [IADDR_SPACE_BITS-2:0]   i_pc,
  input  wire logic [31:0]                   i_instr,
  input  wire logic                          i_reg_write,
  input  wire logic                          i_mem_read,
  input  wire logic                          i_mem_write,
  input  wire logic [PIPE_STAGES-1:0]        i_stage_flush,
  input  wire logic [PIPE_STAGES-1:0]        i_stage_stall,
  input  wire logic [31:0]                   i_mem_addr,
  input  wire logic [31:0]                   i_reg_data,
  input  wire logic                          i_arm,
  input  wire logic                          i_stop,
  input  wire logic [1:0]                    i_mode,
  input  wire logic [IADDR_SPACE_BITS-1:0]   i_trig_pc,
  input  wire logic [$clog2(DEPTH):0]        i_post_count,
  rv_trace_buffer_if.slave                   rd_if,
  output logic [1:0]                         o_state,
  output logic [$clog2(DEPTH):0]             o_count,
  output logic                               o_overflow,
  output logic                               o_trig_hit
);

  localparam int c_aw   = $clog2(DEPTH);
  localparam int c_cw   = c_aw + 1;
  localparam int c_last = PIPE_STAGES - 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  trace_stage_t stage_q [PIPE_STAGES];
  trace_stage_t stage_d [PIPE_STAGES];
  logic [31:0]  addr_q, addr_d;

  trace_state_t      state_q, state_d;
  trace_mode_t       mode_q, mode_d;
  logic [c_cw-1:0]   post_q, post_d;
  logic [c_cw-1:0]   count_q, count_d;
  logic [c_aw-1:0]   wptr_q, wptr_d;
  logic [c_aw-1:0]   rptr_q, rptr_d;
  logic              ovf_q, ovf_d;
  logic              trig_q, trig_d;
  logic              rd_valid_q;

  logic              w_retire;
  logic              w_trig_match;
  logic              w_we;
  logic              w_re;
  trace_stage_t      w_last;
  trace_entry_t      w_entry;
  trace_entry_t      w_rdata;

  always_comb begin
    stage_d = stage_q;
    addr_d  = addr_q;
    if (i_stage_flush[0]) begin
      stage_d[0] = '0;
    end else if (!i_stage_stall[0]) begin
      stage_d[0].pc    = c_trace_pc_bits'({i_pc, 1'b0});
      stage_d[0].instr = i_instr;
      stage_d[0].flags = {i_mem_write, i_mem_read, i_reg_write};
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (i_stage_flush[k]) begin
        stage_d[k] = '0;
      end else if (!i_stage_stall[k]) begin
        stage_d[k] = stage_q[k-1];
      end
    end
    // Memory address only exists in the retiring stage.
    if (i_stage_flush[c_last]) begin
      addr_d = '0;
    end else if (!i_stage_stall[c_last]) begin
      addr_d = i_mem_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= '0;
      end
      addr_q <= '0;
    end else begin
      stage_q <= stage_d;
      addr_q  <= addr_d;
    end
  end

  assign w_last       = stage_q[c_last];
  assign w_retire     = (w_last.instr != '0) && !i_stage_stall[c_last];
  assign w_trig_match = (w_last.pc[IADDR_SPACE_BITS-1:0] == i_trig_pc);

  always_comb begin
    w_entry.pc    = w_last.pc;
    w_entry.instr = w_last.instr;
    w_entry.data  = w_last.flags[0] ? i_reg_data : 32'd0;
    w_entry.addr  = addr_q;
    w_entry.flags = w_last.flags;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    post_d  = post_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    trig_d  = trig_q;
    w_we    = 1'b0;
    w_re    = 1'b0;
    if (i_arm) begin
      state_d = ST_RUN;
      mode_d  = decode_mode(i_mode);
      post_d  = i_post_count;
      count_d = '0;
      wptr_d  = '0;
      ovf_d   = 1'b0;
      trig_d  = 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_POST: begin
          if (w_retire) begin
            w_we   = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (count_q == c_full) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
            if (state_q == ST_POST) begin
              post_d = post_q - 1'b1;
              if (post_q == c_cw'(1)) begin
                state_d = ST_DONE;
              end
            end else if (mode_q == MODE_STOP_FULL && count_d == c_full) begin
              state_d = ST_DONE;
            end else if (mode_q == MODE_TRIGGER && w_trig_match) begin
              trig_d  = 1'b1;
              state_d = (post_q == '0) ? ST_DONE : ST_POST;
            end
          end
          if (i_stop) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_if.i_rd_req && count_q != '0) begin
            w_re    = 1'b1;
            rptr_d  = rptr_q + 1'b1;
            count_d = count_q - 1'b1;
          end
        end
        default: ;
      endcase
      // After a wrap the oldest surviving entry sits at the write pointer.
      if (state_d == ST_DONE && state_q != ST_DONE) begin
        rptr_d = ovf_d ? wptr_d : '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_WRAP;
      post_q     <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      trig_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      post_q     <= post_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ovf_q      <= ovf_d;
      trig_q     <= trig_d;
      rd_valid_q <= w_re;
    end
  end

  rv_trace_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_we),
    .i_waddr (wptr_q),
    .i_wdata (w_entry),
    .i_re    (w_re),
    .i_raddr (rptr_q),
    .o_rdata (w_rdata)
  );

  assign rd_if.o_rd_valid = rd_valid_q;
  assign rd_if.o_rd_pc    = w_rdata.pc[IADDR_SPACE_BITS-1:0];
  assign rd_if.o_rd_instr = w_rdata.instr;
  assign rd_if.o_rd_data  = w_rdata.data;
  assign rd_if.o_rd_addr  = w_rdata.addr;
  assign rd_if.o_rd_flags = w_rdata.flags;

  assign o_state    = state_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_trig_hit = trig_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_trace_buffer
// Description : Self-checking bench: queue-based reference model plus directed
//               and randomized capture/drain sessions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_trace_buffer;

  localparam int DEPTH = 16;
  localparam int PIPE  = 3;
  localparam int CW    = 5;
  localparam int L     = PIPE - 1;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [30:0]     i_pc;
  logic [31:0]     i_instr;
  logic            i_reg_write, i_mem_read, i_mem_write;
  logic [PIPE-1:0] i_stage_flush, i_stage_stall;
  logic [31:0]     i_mem_addr, i_reg_data;
  logic            i_arm, i_stop;
  logic [1:0]      i_mode;
  logic [31:0]     i_trig_pc;
  logic [CW-1:0]   i_post_count;
  logic [1:0]      o_state;
  logic [CW-1:0]   o_count;
  logic            o_overflow, o_trig_hit;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 i_clk = ~i_clk;

  rv_trace_buffer_if #(.IADDR_SPACE_BITS(32)) rd_if ();

  rv_trace_buffer #(
    .IADDR_SPACE_BITS (32),
    .DEPTH            (DEPTH),
    .PIPE_STAGES      (PIPE)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc          (i_pc),
    .i_instr       (i_instr),
    .i_reg_write   (i_reg_write),
    .i_mem_read    (i_mem_read),
    .i_mem_write   (i_mem_write),
    .i_stage_flush (i_stage_flush),
    .i_stage_stall (i_stage_stall),
    .i_mem_addr    (i_mem_addr),
    .i_reg_data    (i_reg_data),
    .i_arm         (i_arm),
    .i_stop        (i_stop),
    .i_mode        (i_mode),
    .i_trig_pc     (i_trig_pc),
    .i_post_count  (i_post_count),
    .rd_if         (rd_if),
    .o_state       (o_state),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_trig_hit    (o_trig_hit)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  flags;
  } ent_t;

  ent_t        mq[$];
  int          m_state, m_mode, m_post;
  bit          m_ovf, m_trig, m_rdv;
  ent_t        m_rd;
  logic [31:0] s_pc    [PIPE];
  logic [31:0] s_instr [PIPE];
  logic [2:0]  s_fl    [PIPE];
  logic [31:0] s_addr;

  always @(posedge i_clk or posedge i_reset) begin : model
    ent_t e;
    bit   ret;
    if (i_reset) begin
      mq.delete();
      m_state = 0; m_mode = 0; m_post = 0;
      m_ovf = 0; m_trig = 0; m_rdv = 0; m_rd = '0;
      for (int k = 0; k < PIPE; k++) begin
        s_pc[k] = 0; s_instr[k] = 0; s_fl[k] = 0;
      end
      s_addr = 0;
    end else begin
      ret     = (s_instr[L] != 0) && !i_stage_stall[L];
      e.pc    = s_pc[L];
      e.instr = s_instr[L];
      e.data  = s_fl[L][0] ? i_reg_data : 32'd0;
      e.addr  = s_addr;
      e.flags = s_fl[L];
      if (i_stage_flush[L]) s_addr = 0;
      else if (!i_stage_stall[L]) s_addr = i_mem_addr;
      for (int k = L; k >= 1; k--) begin
        if (i_stage_flush[k]) begin
          s_pc[k] = 0; s_instr[k] = 0; s_fl[k] = 0;
        end else if (!i_stage_stall[k]) begin
          s_pc[k] = s_pc[k-1]; s_instr[k] = s_instr[k-1]; s_fl[k] = s_fl[k-1];
        end
      end
      if (i_stage_flush[0]) begin
        s_pc[0] = 0; s_instr[0] = 0; s_fl[0] = 0;
      end else if (!i_stage_stall[0]) begin
        s_pc[0] = {i_pc, 1'b0}; s_instr[0] = i_instr;
        s_fl[0] = {i_mem_write, i_mem_read, i_reg_write};
      end
      m_rdv = 0;
      if (i_arm) begin
        m_state = 1;
        mq.delete();
        m_ovf = 0; m_trig = 0;
        m_mode = (i_mode == 2'd3) ? 0 : int'(i_mode);
        m_post = int'(i_post_count);
      end else if (m_state == 1 || m_state == 2) begin
        if (ret) begin
          mq.push_back(e);
          if (mq.size() > DEPTH) begin
            void'(mq.pop_front());
            m_ovf = 1;
          end
          if (m_state == 2) begin
            m_post--;
            if (m_post == 0) m_state = 3;
          end else if (m_mode == 1 && mq.size() == DEPTH) begin
            m_state = 3;
          end else if (m_mode == 2 && e.pc == i_trig_pc) begin
            m_trig  = 1;
            m_state = (m_post == 0) ? 3 : 2;
          end
        end
        if (i_stop) m_state = 3;
      end else if (m_state == 3 && rd_if.i_rd_req && mq.size() > 0) begin
        m_rdv = 1;
        m_rd  = mq.pop_front();
      end
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      chk("state",    64'(o_state),          64'(m_state));
      chk("count",    64'(o_count),          64'(mq.size()));
      chk("overflow", 64'(o_overflow),       64'(m_ovf));
      chk("trig_hit", 64'(o_trig_hit),       64'(m_trig));
      chk("rd_valid", 64'(rd_if.o_rd_valid), 64'(m_rdv));
      chk("rd_pc",    64'(rd_if.o_rd_pc),    64'(m_rd.pc));
      chk("rd_instr", 64'(rd_if.o_rd_instr), 64'(m_rd.instr));
      chk("rd_data",  64'(rd_if.o_rd_data),  64'(m_rd.data));
      chk("rd_addr",  64'(rd_if.o_rd_addr),  64'(m_rd.addr));
      chk("rd_flags", 64'(rd_if.o_rd_flags), 64'(m_rd.flags));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic bubble_inputs();
    i_instr = 0; i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
    i_stage_flush = 0; i_stage_stall = 0; i_arm = 0; i_stop = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] ins);
    i_pc        = a[31:1];
    i_instr     = ins;
    i_reg_write = 1'($urandom);
    i_mem_read  = 1'($urandom);
    i_mem_write = 1'($urandom);
    i_mem_addr  = $urandom;
    i_reg_data  = $urandom;
    tick();
    bubble_inputs();
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [CW-1:0] pc_cnt, input logic [31:0] tpc);
    i_arm = 1; i_mode = m; i_post_count = pc_cnt; i_trig_pc = tpc;
    tick();
    i_arm = 0;
  endtask

  task automatic do_stop();
    i_stop = 1;
    tick();
    i_stop = 0;
  endtask

  task automatic drain_and_check(input logic [31:0] first_pc, input int n);
    rd_if.i_rd_req = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("pop_valid", 64'(rd_if.o_rd_valid), 64'd1);
      chk("pop_pc", 64'(rd_if.o_rd_pc), 64'(first_pc + 32'(4 * i)));
    end
    rd_if.i_rd_req = 0;
    tick();
  endtask

  initial begin
    i_reset = 1'b1;
    bubble_inputs();
    i_pc = 0; i_mem_addr = 0; i_reg_data = 0; i_mode = 0; i_trig_pc = 0; i_post_count = 0;
    rd_if.i_rd_req = 0;
    tick();
    tick();
    chk("reset_state", 64'(o_state), 64'd0);
    chk("reset_count", 64'(o_count), 64'd0);
    chk("reset_valid", 64'(rd_if.o_rd_valid), 64'd0);
    chk("reset_rd_pc", 64'(rd_if.o_rd_pc), 64'd0);
    i_reset = 1'b0;
    cmp_en  = 1'b1;
    tick();

    // WRAP: 20 retires, the first four are overwritten
    do_arm(2'd0, 0, 0);
    for (int i = 0; i < 20; i++) issue(32'h100 + 32'(4 * i), 32'h13 + 32'(i << 7));
    repeat (3) tick();
    do_stop();
    chk("wrap_state", 64'(o_state), 64'd3);
    chk("wrap_count", 64'(o_count), 64'd16);
    chk("wrap_ovf",   64'(o_overflow), 64'd1);
    drain_and_check(32'h110, 16);

    // STOP_FULL: stops itself after the 16th record
    do_arm(2'd1, 0, 0);
    for (int i = 0; i < 20; i++) issue(32'h100 + 32'(4 * i), 32'h33 + 32'(i << 7));
    repeat (3) tick();
    chk("full_state", 64'(o_state), 64'd3);
    chk("full_count", 64'(o_count), 64'd16);
    chk("full_ovf",   64'(o_overflow), 64'd0);
    drain_and_check(32'h100, 16);

    // TRIGGER at 0x120 with three post-trigger records
    do_arm(2'd2, 5'd3, 32'h120);
    for (int i = 0; i < 20; i++) issue(32'h100 + 32'(4 * i), 32'h03 + 32'(i << 7));
    repeat (3) tick();
    chk("trig_state", 64'(o_state), 64'd3);
    chk("trig_hit",   64'(o_trig_hit), 64'd1);
    chk("trig_count", 64'(o_count), 64'd12);
    drain_and_check(32'h100, 12);

    // Last-stage stall for two cycles, then a flushed instruction
    do_arm(2'd0, 0, 0);
    i_pc = 31'h100; i_instr = 32'h00A00093; i_reg_write = 1; i_reg_data = $urandom;
    tick();
    bubble_inputs();
    tick();
    tick();
    i_stage_stall = 3'b100;
    i_reg_data = $urandom;
    tick();
    tick();
    i_stage_stall = 3'b000;
    i_reg_data = 32'h12345678;
    tick();
    chk("stall_count", 64'(o_count), 64'd1);
    issue(32'h300, 32'h00100113);
    i_stage_flush = 3'b010;
    tick();
    i_stage_flush = 3'b000;
    repeat (3) tick();
    chk("flush_count", 64'(o_count), 64'd1);
    do_stop();
    rd_if.i_rd_req = 1;
    tick();
    rd_if.i_rd_req = 0;
    chk("stall_pc",    64'(rd_if.o_rd_pc), 64'h200);
    chk("stall_instr", 64'(rd_if.o_rd_instr), 64'h00A00093);
    chk("stall_data",  64'(rd_if.o_rd_data), 64'h12345678);

    // Read-port edges
    rd_if.i_rd_req = 1;
    tick();
    rd_if.i_rd_req = 0;
    chk("empty_pop_valid", 64'(rd_if.o_rd_valid), 64'd0);
    do_arm(2'd0, 0, 0);
    issue(32'h500, 32'h1); issue(32'h504, 32'h2); issue(32'h508, 32'h3);
    repeat (3) tick();
    rd_if.i_rd_req = 1;
    tick();
    rd_if.i_rd_req = 0;
    chk("run_pop_valid", 64'(rd_if.o_rd_valid), 64'd0);
    chk("run_pop_count", 64'(o_count), 64'd3);
    do_stop();
    drain_and_check(32'h500, 3);

    // Reset while in POST
    do_arm(2'd2, 5'd5, 32'h400);
    issue(32'h400, 32'h7);
    repeat (3) tick();
    chk("post_state", 64'(o_state), 64'd2);
    i_reset = 1;
    tick();
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_trig",  64'(o_trig_hit), 64'd0);
    chk("rst_valid", 64'(rd_if.o_rd_valid), 64'd0);
    i_reset = 0;
    tick();
    do_arm(2'd0, 0, 0);
    chk("rearm_state", 64'(o_state), 64'd1);

    // Randomized sessions against the model
    for (int it = 0; it < 12; it++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      do_arm(2'($urandom), 5'($urandom_range(0, DEPTH)), a);
      repeat (80) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        i_pc          = a[31:1];
        i_instr       = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
        i_reg_write   = 1'($urandom);
        i_mem_read    = 1'($urandom);
        i_mem_write   = 1'($urandom);
        i_mem_addr    = $urandom;
        i_reg_data    = $urandom;
        i_stage_flush = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
        i_stage_stall = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
        i_stop        = ($urandom_range(0, 99) == 0);
        i_arm         = ($urandom_range(0, 149) == 0);
        i_mode        = 2'($urandom);
        rd_if.i_rd_req = 1'($urandom);
        tick();
      end
      bubble_inputs();
      rd_if.i_rd_req = 0;
      do_stop();
      rd_if.i_rd_req = 1;
      repeat (DEPTH + 2) tick();
      rd_if.i_rd_req = 0;
      tick();
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_trace_buffer.md
Name: rv_trace_buffer

Overview:
- Synthesizable retirement trace buffer for the FlexRV32 core.
- Shadows the instruction stream through a parametrised number of pipeline stages, using each stage's flush and stall.
- Records every retired instruction into a circular on-chip buffer: PC, opcode, register write data, memory address and flags.
- Supports free-run, stop-on-full and PC-trigger-with-post-count modes; a debug host drains entries oldest-first through a request/valid read port.

Parameters:
- IADDR_SPACE_BITS, 32, instruction address width; PC bit 0 is implied zero.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- PIPE_STAGES, 3, shadow stages from capture point to retire (exec, exec2, write); minimum 1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_pc  in  IADDR_SPACE_BITS-1  PC bits [IADDR_SPACE_BITS-1:1] at capture stage.
- i_instr  in  32  instruction at capture stage.
- i_reg_write  in  1  capture-stage register write flag.
- i_mem_read  in  1  capture-stage memory read flag.
- i_mem_write  in  1  capture-stage memory write flag.
- i_stage_flush  in  PIPE_STAGES  per-stage flush, index 0 = first shadow stage.
- i_stage_stall  in  PIPE_STAGES  per-stage stall.
- i_mem_addr  in  32  memory address, latched into the last stage on its load.
- i_reg_data  in  32  register write data, sampled at retire.
- i_arm  in  1  pulse: start or restart recording.
- i_stop  in  1  pulse: stop recording.
- i_mode  in  2  sampled at i_arm: 0 WRAP, 1 STOP_FULL, 2 TRIGGER, 3 reserved (treated as WRAP).
- i_trig_pc  in  IADDR_SPACE_BITS  trigger PC, full byte address.
- i_post_count  in  $clog2(DEPTH)+1  entries to record after the trigger entry; sampled at i_arm.
- i_rd_req  in  1  pop oldest entry.
- o_rd_valid  out  1  read data valid.
- o_rd_pc  out  IADDR_SPACE_BITS  entry PC.
- o_rd_instr  out  32  entry opcode.
- o_rd_data  out  32  entry register write data.
- o_rd_addr  out  32  entry memory address.
- o_rd_flags  out  3  {mem_write, mem_read, reg_write}.
- o_state  out  2  IDLE=0, RUN=1, POST=2, DONE=3.
- o_count  out  $clog2(DEPTH)+1  valid entries held.
- o_overflow  out  1  WRAP mode overwrote at least one entry.
- o_trig_hit  out  1  trigger matched during this recording.

Behaviour:
- Reset (async, i_reset=1):
  - all shadow stages cleared (instr=0, flags=0), pointers and counters 0;
  - state IDLE, o_count 0, o_overflow 0, o_trig_hit 0, o_rd_valid 0, all o_rd_* 0.
  - Reset mid-recording discards the buffer contents.
- Shadow stage k, per clock:
  - i_stage_flush[k] has priority and clears the stage;
  - else if !i_stage_stall[k], the stage loads from stage k-1 (stage 0 loads {i_pc,1'b0} and the inputs);
  - else the stage holds.
- Retire event: last stage has instr!=0 and !i_stage_stall[PIPE_STAGES-1]. Bubbles (instr==0) are never recorded.
- Record:
  - happens on a retire event in RUN or POST;
  - the entry is written at the same clock edge; wptr and o_count update at that edge;
  - o_rd_data = i_reg_data when reg_write, else 0.
- Pointers: wptr wraps DEPTH-1 -> 0.
- o_count saturates at DEPTH. In WRAP mode, a write at count==DEPTH sets o_overflow (sticky until i_arm).
- State transitions:
  - i_arm in any state -> RUN: clears wptr, o_count, o_overflow, o_trig_hit; latches mode and post count. A retire in the i_arm cycle is not recorded.
  - RUN, WRAP: remains until i_stop.
  - RUN, STOP_FULL: -> DONE at the edge where o_count becomes DEPTH.
  - RUN, TRIGGER: a retire with PC==i_trig_pc records that entry and sets o_trig_hit. Then -> DONE if post count is 0, else -> POST.
  - TRIGGER buffer full before the trigger: behaves as WRAP (overwrite, overflow).
  - POST: each recorded retire decrements post count; the record that reaches 0 -> DONE. i_stop also -> DONE.
  - i_stop in IDLE or DONE: ignored.
  - Simultaneous i_stop and retire in RUN/POST: the entry is recorded, then DONE.
  - Simultaneous i_arm and i_stop: i_arm wins.
- Entering DONE: rptr = o_overflow ? wptr : 0, so the oldest entry is first.
- Read port:
  - active only in DONE; i_rd_req with o_count>0 pops;
  - o_rd_* registered, o_rd_valid high exactly one cycle after the request;
  - rptr wraps; o_count decrements.
  - i_rd_req with o_count==0, or outside DONE: ignored, o_rd_valid stays 0.
  - Back-to-back requests give one entry per cycle.
  - o_rd_* hold their last values when o_rd_valid=0.

Decomposition:
- Package rv_trace_pkg:
  - trace_state_t enum (IDLE, RUN, POST, DONE);
  - trace_mode_t enum (WRAP, STOP_FULL, TRIGGER);
  - trace_entry_t packed struct {pc, instr, data, addr, flags}.
- Sub-module rv_trace_ram: DEPTH x trace_entry_t, one write port, one registered read port.

Test Plan:
- WRAP, DEPTH=16: 20 retires PC 0x100..0x14C step 4, i_stop -> DONE, o_count=16, o_overflow=1; 16 pops return 0x110..0x14C in order.
- STOP_FULL: 20 retires -> DONE after the 16th; o_count=16, o_overflow=0; first pop PC 0x100, last 0x13C.
- TRIGGER, i_trig_pc=0x120, post=3: retires 0x100..0x14C -> DONE after 0x12C recorded; o_trig_hit=1; last popped PC 0x12C.
- Stall/flush, PIPE_STAGES=3: instr 0x00A00093 at PC 0x200 with last-stage stall held 2 cycles -> exactly one entry, data = i_reg_data at release; a flushed stage-1 instr is never recorded.
- Read edges: pop in DONE with o_count=0 -> o_rd_valid stays 0; pop in RUN -> ignored; 3 back-to-back pops -> 3 consecutive valid cycles.
- i_reset=1 asserted in POST -> next cycle state IDLE, o_count=0, o_trig_hit=0, o_rd_valid=0; i_arm after release -> RUN.
